// File: rtl/shift_unit_pkg.sv
// Shared shifter definitions: op codes and FSM state encodings.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package shift_unit_pkg;

  // Shift operation codes driven by the control unit. Codes 3'b110 and 3'b111 act as PASS.
  localparam logic [2:0] SH_PASS = 3'b000;
  localparam logic [2:0] SH_SLL  = 3'b001;
  localparam logic [2:0] SH_SRL  = 3'b010;
  localparam logic [2:0] SH_SRA  = 3'b011;
  localparam logic [2:0] SH_ROR  = 3'b100;
  localparam logic [2:0] SH_ROL  = 3'b101;

  // Sequencer states.
  typedef enum logic [1:0] {
    SH_IDLE  = 2'd0,
    SH_SHIFT = 2'd1,
    SH_DONE  = 2'd2
  } sh_state_t;

endpackage

// File: rtl/shift_step.sv
// One-bit shift step for every op code. ROR/ROL exist only when SHIFT_ROTATE_EN is defined.
// Latency: purely combinational.
// Backpressure: none; the output follows the inputs.
module shift_step
  import shift_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Decode the op and move the word by one bit position. Unknown codes pass through.
  always_comb begin
    dout = din;
    case (op)
      SH_SLL: dout = {din[WIDTH-2:0], 1'b0};
      SH_SRL: dout = {1'b0, din[WIDTH-1:1]};
      SH_SRA: dout = {din[WIDTH-1], din[WIDTH-1:1]};
`ifdef SHIFT_ROTATE_EN
      SH_ROR: dout = {din[0], din[WIDTH-1:1]};
      SH_ROL: dout = {din[WIDTH-2:0], din[WIDTH-1]};
`endif
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Multicycle shifter with one bit per clock. Rotates are present only with SHIFT_ROTATE_EN.
// Latency: done pulses n+1 cycles after start is accepted; the next start is taken once busy drops.
// Backpressure: start is sampled only in IDLE. A start seen while busy is dropped, not queued.
module shift_unit
  import shift_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CNT_W-1:0] n,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done
);

  sh_state_t        state_q, state_d;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] step_out;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       op_q;
  logic             busy_q, done_q;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op   (op_q),
    .din  (sr_q),
    .dout (step_out)
  );

  // Next-state logic. A zero shift amount goes straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SH_IDLE:  if (start) state_d = (n != '0) ? SH_SHIFT : SH_DONE;
      SH_SHIFT: if (cnt_q == CNT_W'(1)) state_d = SH_DONE;
      SH_DONE:  state_d = SH_IDLE;
      default:  state_d = SH_IDLE;
    endcase
  end

  // State, operand, counter and op registers, plus busy and done flags registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SH_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      op_q    <= SH_PASS;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != SH_IDLE);
      done_q  <= (state_d == SH_DONE);
      case (state_q)
        SH_IDLE: begin
          if (start) begin
            sr_q  <= data_in;
            cnt_q <= n;
            op_q  <= op;
          end
        end
        SH_SHIFT: begin
          sr_q  <= step_out;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign data_out = sr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/shift_unit.md
# shift_unit

Multicycle 32-bit shifter fed by the shift-source multiplexer. On a `start` pulse it latches the selected 32-bit operand and a 5-bit shift amount. It then shifts one bit position per clock until the count is exhausted and pulses `done`. The result is held on `data_out` for the register-file and PC-source write-back muxes. It replaces a single-cycle barrel shifter so the control FSM can sequence shifts like other multicycle operations.

## Interface
- `WIDTH`, default 32: operand/result width; only 32 is supported.
- `CNT_W`, default 5: shift-amount width, equal to log2(`WIDTH`).
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `op` in 3: shift operation, latched with `start`.
- `data_in` in 32: operand from the shift-source mux, latched with `start`.
- `n` in 5: shift amount 0..31, latched with `start`.
- `data_out` out 32: shift register contents; final result once `done` has pulsed.
- `busy` out 1: high while in SHIFT or DONE.
- `done` out 1: one-cycle pulse when the result is valid.

## Operation
- Op codes:
  - 3'b000 PASS
  - 3'b001 SLL (zero fill)
  - 3'b010 SRL (zero fill)
  - 3'b011 SRA (bit 31 replicated)
  - 3'b100 ROR
  - 3'b101 ROL
  - 3'b110 and 3'b111 are illegal and behave as PASS.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE with `start`=1: latch `data_in` into the shift register, `n` into the counter and `op` into the op register. Go to SHIFT if `n`≠0, else go to DONE.
  - SHIFT: apply one single-bit step of the latched op and decrement the counter. When the counter reaches 0 (after the step), go to DONE.
  - DONE: `done`=1 for exactly one cycle, then return to IDLE unconditionally.
- `start` is ignored in SHIFT and DONE. No queueing; the request is dropped.
- `data_in`, `n` and `op` are don't-care except in the cycle `start` is accepted.
- PASS (and illegal codes) still spend `n` cycles in SHIFT. The register is unchanged, so latency is independent of op.
- `data_out` is held from DONE until the next accepted `start`. On acceptance it shows the raw operand on the following cycle.
- Reset values: state IDLE, `data_out`=32'h0, counter 0, op register 3'b000, `busy`=0, `done`=0.
- Reset asserted mid-operation aborts at the next edge with all reset values. No `done` is produced for the aborted request.
- Reset has priority over `start` in the same cycle.

## Timing
- `start` accepted at edge E0. The next `n` edges each perform one shift. `done` is high in the cycle after edge E0+`n`, i.e. n+1 cycles after the start cycle.
- `n`=0 gives `done` in cycle 1 with `data_out`=operand. `n`=31 gives `done` in cycle 32.
- `busy` rises in the cycle after acceptance and falls together with `done`. A new `start` is accepted in the cycle `busy` is low again (back-to-back throughput n+2 cycles).
- `done` and `busy` are registered. No combinational input-to-output path.

## Configuration
- `SHIFT_ROTATE_EN` defined: ROR and ROL are implemented as above.
- `SHIFT_ROTATE_EN` undefined: codes 3'b100 and 3'b101 are illegal and behave as PASS with unchanged latency. No rotate datapath logic is generated.

## Structure
- Shared package/include holds:
  - op-code localparams (`SH_PASS`, `SH_SLL`, `SH_SRL`, `SH_SRA`, `SH_ROR`, `SH_ROL`)
  - FSM state encodings (`SH_IDLE`, `SH_SHIFT`, `SH_DONE`)
  - so the control unit drives `op` by name.
- Single sub-module `shift_step`: combinational one-bit step (op, 32-bit in → 32-bit out). It holds all op decoding, including the `SHIFT_ROTATE_EN` guard.
- `shift_unit` holds the FSM, counter and registers.

## Test plan
- Reset, then hold `start`=0 → `data_out`=0, `busy`=0, `done`=0 for 10 cycles.
- SLL, `data_in`=32'h0000_0001, `n`=4 → `done` in cycle 5, `data_out`=32'h0000_0010. SRA of 32'h8000_0000 by 31 → `done` in cycle 32, `data_out`=32'hFFFF_FFFF.
- SRL of 32'h8000_0000 by 0 → `done` in cycle 1, `data_out`=32'h8000_0000. Illegal op 3'b111 with `n`=3 → `done` in cycle 4, operand unchanged.
- ROR of 32'h0000_0001 by 1 → 32'h8000_0000. ROL of 32'h8000_0001 by 4 → 32'h0000_0018. Without `SHIFT_ROTATE_EN`, the same stimuli return the operands unchanged.
- Second `start` pulsed while busy (SLL by 8) → ignored; a single `done` with the first result only.
- `reset` asserted at cycle 3 of a 10-cycle shift → next cycle all outputs are at reset values and no `done` follows. A new `start` then completes normally.
